// File: rtl/fifo_sc_ctrl.sv
// Purpose: single-clock FIFO controller sequencing one generic_dpram into a 2^aw deep FIFO.
// Latency: a push is stored at its edge and counted from the next cycle; rd_valid follows an accepted pop by one cycle.
// Backpressure: push while full and pop while empty are dropped. A flush (clr) overrides both.
//
// Ports:
//   clk, rst (async active-high), clr (sync flush), push, pop     - control inputs
//   full, empty, almost_full, almost_empty, count, rd_valid        - status (registered decodes)
//   ram_waddr, ram_we, ram_wce, ram_raddr, ram_rce, ram_oe         - to generic_dpram
//   overflow, underflow                                            - sticky errors, only with FIFO_SC_ERR_EN
//
// Optional feature macro: FIFO_SC_ERR_EN (adds the sticky overflow/underflow flags).
// The data path (di/do) runs directly between the user and the RAM and does not pass through here.

module fifo_sc_ctrl #(
  parameter int aw     = 5,
  parameter int af_lvl = (1 << aw) - 2,
  parameter int ae_lvl = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          push,
  input  logic          pop,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [aw:0]   count,
  output logic          rd_valid,
  output logic [aw-1:0] ram_waddr,
  output logic          ram_we,
  output logic          ram_wce,
  output logic [aw-1:0] ram_raddr,
  output logic          ram_rce,
  output logic          ram_oe
`ifdef FIFO_SC_ERR_EN
  ,
  output logic          overflow,
  output logic          underflow
`endif
);

  // Elaboration-time parameter legality.
  if (af_lvl < 1 || af_lvl > (1 << aw)) begin : g_bad_af_lvl
    $error("fifo_sc_ctrl: af_lvl out of range 1..2^aw");
  end
  if (ae_lvl < 0 || ae_lvl >= (1 << aw)) begin : g_bad_ae_lvl
    $error("fifo_sc_ctrl: ae_lvl out of range 0..2^aw-1");
  end

  localparam logic [aw:0] DEPTH  = {1'b1, {aw{1'b0}}};
  localparam logic [aw:0] ONE    = {{aw{1'b0}}, 1'b1};
  localparam logic [aw:0] ZERO   = '0;
  localparam logic [aw:0] AF_LVL = af_lvl[aw:0];
  localparam logic [aw:0] AE_LVL = ae_lvl[aw:0];

  // Pointers carry one extra lap bit; only the low aw bits address the RAM.
  logic [aw:0] wp_q, wp_d;
  logic [aw:0] rp_q, rp_d;
  logic [aw:0] count_q, count_d;
  logic        rd_valid_q, rd_valid_d;
  logic        oe_q, oe_d;
  logic        push_ok, pop_ok;

`ifdef FIFO_SC_ERR_EN
  logic        overflow_q, overflow_d;
  logic        underflow_q, underflow_d;
`endif

  // Status is decoded purely from the registered count.
  assign full         = (count_q == DEPTH);
  assign empty        = (count_q == ZERO);
  assign almost_full  = (count_q >= AF_LVL);
  assign almost_empty = (count_q <= AE_LVL);
  assign count        = count_q;
  assign rd_valid     = rd_valid_q;

  // A push while full is refused even alongside a pop, so an accepted read
  // never shares an address with an accepted write in the same cycle.
  assign push_ok = push & ~full & ~clr;
  assign pop_ok  = pop & ~empty & ~clr;

  assign ram_waddr = wp_q[aw-1:0];
  assign ram_raddr = rp_q[aw-1:0];
  // Enables are forced low while rst is asserted, independent of the flops.
  assign ram_we    = push_ok & ~rst;
  assign ram_wce   = push_ok & ~rst;
  // rce only on accepted pops so the RAM output register holds between pops.
  assign ram_rce   = pop_ok & ~rst;
  assign ram_oe    = oe_q;

  always_comb begin
    wp_d       = wp_q;
    rp_d       = rp_q;
    count_d    = count_q;
    rd_valid_d = pop_ok;
    oe_d       = 1'b1;
    if (clr) begin
      wp_d    = '0;
      rp_d    = '0;
      count_d = '0;
    end else begin
      if (push_ok) wp_d = wp_q + ONE;
      if (pop_ok)  rp_d = rp_q + ONE;
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + ONE;
        2'b01:   count_d = count_q - ONE;
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp_q       <= '0;
      rp_q       <= '0;
      count_q    <= '0;
      rd_valid_q <= 1'b0;
      oe_q       <= 1'b0;
    end else begin
      wp_q       <= wp_d;
      rp_q       <= rp_d;
      count_q    <= count_d;
      rd_valid_q <= rd_valid_d;
      oe_q       <= oe_d;
    end
  end

`ifdef FIFO_SC_ERR_EN
  // Sticky error flags: cleared only by rst, not by clr.
  always_comb begin
    overflow_d  = overflow_q | (push & full);
    underflow_d = underflow_q | (pop & empty);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      overflow_q  <= overflow_d;
      underflow_q <= underflow_d;
    end
  end

  assign overflow  = overflow_q;
  assign underflow = underflow_q;
`endif

endmodule

// File: tb/tb_fifo_sc_ctrl.sv
// Purpose: self-checking bench for fifo_sc_ctrl with a behavioural dual-port RAM attached.
// Latency: reference model is a queue updated at each active edge; outputs are sampled on the falling edge.
// Backpressure: the model refuses pushes at 32 entries and pops at 0, and a flush empties it.

module tb_fifo_sc_ctrl;

  localparam int DEPTH = 32;
  localparam int AF    = 30;
  localparam int AE    = 2;

  logic       clk, rst, clr, push, pop;
  logic       full, empty, almost_full, almost_empty, rd_valid;
  logic [5:0] count;
  logic [4:0] ram_waddr, ram_raddr;
  logic       ram_we, ram_wce, ram_rce, ram_oe;
`ifdef FIFO_SC_ERR_EN
  logic       overflow, underflow;
`endif
  logic [7:0] di;
  logic [7:0] dout_q;
  logic [7:0] mem [DEPTH];
  wire  [7:0] ram_do = ram_oe ? dout_q : 8'hzz;

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [7:0] m_q[$];
  logic       m_rdv;
  logic [7:0] m_rd;
  logic       m_ovf, m_udf;
  int         m_pushes;

  fifo_sc_ctrl dut (
    .clk(clk), .rst(rst), .clr(clr), .push(push), .pop(pop),
    .full(full), .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
    .count(count), .rd_valid(rd_valid),
    .ram_waddr(ram_waddr), .ram_we(ram_we), .ram_wce(ram_wce),
    .ram_raddr(ram_raddr), .ram_rce(ram_rce), .ram_oe(ram_oe)
`ifdef FIFO_SC_ERR_EN
    , .overflow(overflow), .underflow(underflow)
`endif
  );

  // Behavioural RAM: registered output, X on a same-address read/write collision.
  always @(posedge clk) if (ram_we && ram_wce) mem[ram_waddr] <= di;
  always @(posedge clk or posedge rst) begin
    if (rst) dout_q <= 8'h00;
    else if (ram_rce) dout_q <= (ram_we && ram_waddr == ram_raddr) ? 8'hxx : mem[ram_raddr];
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic model_reset();
    m_q.delete();
    m_rdv = 1'b0;
    m_rd  = 8'h00;
    m_ovf = 1'b0;
    m_udf = 1'b0;
  endtask

  // Drive one cycle from a falling edge, advance the model at the rising edge,
  // and return at the next falling edge with inputs idle.
  task automatic drive(input logic p, input logic q, input logic c, input logic [7:0] d);
    int sz;
    logic wok, pok;
    push = p; pop = q; clr = c; di = d;
    @(posedge clk);
    sz  = m_q.size();
    wok = p && !c && sz < DEPTH;
    pok = q && !c && sz > 0;
    if (p && sz == DEPTH) m_ovf = 1'b1;
    if (q && sz == 0)     m_udf = 1'b1;
    m_rdv = pok;
    if (pok) m_rd = m_q.pop_front();
    if (wok) begin m_q.push_back(d); m_pushes++; end
    if (c) m_q.delete();
    @(negedge clk);
    push = 1'b0; pop = 1'b0; clr = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; clr = 1'b0; push = 1'b1; pop = 1'b0; di = 8'h00;
    model_reset();
    #1;
    total++; if (count !== 6'd0) begin bad++; $display("FAIL reset_count got=%0d want=0", count); end
    total++; if (empty !== 1'b1 || full !== 1'b0) begin bad++; $display("FAIL reset_flags empty=%b full=%b want 1/0", empty, full); end
    total++; if (almost_empty !== 1'b1 || almost_full !== 1'b0) begin bad++; $display("FAIL reset_almost ae=%b af=%b want 1/0", almost_empty, almost_full); end
    total++; if (ram_we !== 1'b0 || ram_wce !== 1'b0 || ram_rce !== 1'b0) begin bad++; $display("FAIL reset_ram_en we=%b wce=%b rce=%b want 0", ram_we, ram_wce, ram_rce); end
    total++; if (ram_oe !== 1'b0 || rd_valid !== 1'b0) begin bad++; $display("FAIL reset_oe_rdv oe=%b rdv=%b want 0/0", ram_oe, rd_valid); end
`ifdef FIFO_SC_ERR_EN
    total++; if (overflow !== 1'b0 || underflow !== 1'b0) begin bad++; $display("FAIL reset_err ovf=%b udf=%b want 0", overflow, underflow); end
`endif
    @(negedge clk);
    rst = 1'b0; push = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (ram_oe !== 1'b1) begin bad++; $display("FAIL oe_after_reset got=%b want=1", ram_oe); end
  endtask

  task automatic test_reset_mid_burst();
    for (int i = 0; i < 7; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
    total++; if (count !== 6'd7) begin bad++; $display("FAIL midrst_pre_count got=%0d want=7", count); end
    drive(1'b1, 1'b1, 1'b0, 8'h55);
    total++; if (rd_valid !== m_rdv || ram_do !== m_rd) begin bad++; $display("FAIL midrst_pop rdv=%b do=%h want %b/%h", rd_valid, ram_do, m_rdv, m_rd); end
    push = 1'b1; pop = 1'b1;
    #2 rst = 1'b1;
    #1;
    model_reset();
    total++; if (count !== 6'd0 || empty !== 1'b1) begin bad++; $display("FAIL midrst_async count=%0d empty=%b want 0/1", count, empty); end
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_rdv got=%b want=0", rd_valid); end
    total++; if (ram_we !== 1'b0 || ram_rce !== 1'b0) begin bad++; $display("FAIL midrst_en we=%b rce=%b want 0/0", ram_we, ram_rce); end
    @(negedge clk);
    rst = 1'b0; push = 1'b0; pop = 1'b0;
    drive(1'b1, 1'b0, 1'b0, 8'hA5);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (rd_valid !== 1'b1 || ram_do !== 8'hA5) begin bad++; $display("FAIL midrst_a5 rdv=%b do=%h want 1/a5", rd_valid, ram_do); end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    total++; if (rd_valid !== 1'b0) begin bad++; $display("FAIL midrst_idle_rdv got=%b want=0", rd_valid); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b1, 1'b0, 1'b0, 8'(i));
      total++;
      if (count !== 6'(m_q.size()) || full !== (m_q.size() == DEPTH) ||
          almost_full !== (m_q.size() >= AF) || almost_empty !== (m_q.size() <= AE) || empty !== 1'b0) begin
        bad++;
        $display("FAIL fill_%0d count=%0d full=%b af=%b ae=%b empty=%b want count=%0d", i, count, full, almost_full, almost_empty, empty, m_q.size());
      end
    end
    drive(1'b1, 1'b0, 1'b0, 8'hEE);
    total++; if (count !== 6'd32 || full !== 1'b1) begin bad++; $display("FAIL push_when_full count=%0d full=%b want 32/1", count, full); end
`ifdef FIFO_SC_ERR_EN
    total++; if (overflow !== 1'b1 || underflow !== 1'b0) begin bad++; $display("FAIL overflow_set ovf=%b udf=%b want 1/0", overflow, underflow); end
`endif
    for (int i = 0; i < DEPTH; i++) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      total++;
      if (rd_valid !== 1'b1 || ram_do !== 8'(i) || ram_do !== m_rd || count !== 6'(m_q.size())) begin
        bad++;
        $display("FAIL drain_%0d rdv=%b do=%h count=%0d want 1/%h/%0d", i, rd_valid, ram_do, count, m_rd, m_q.size());
      end
    end
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (rd_valid !== 1'b0 || empty !== 1'b1 || count !== 6'd0) begin bad++; $display("FAIL pop_when_empty rdv=%b empty=%b count=%0d want 0/1/0", rd_valid, empty, count); end
`ifdef FIFO_SC_ERR_EN
    total++; if (underflow !== m_udf || overflow !== m_ovf) begin bad++; $display("FAIL underflow_set udf=%b ovf=%b want %b/%b", underflow, overflow, m_udf, m_ovf); end
`endif
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 5; i++) drive(1'b1, 1'b0, 1'b0, 8'($urandom));
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'b1, 1'b0, 8'($urandom));
      total++;
      if (count !== 6'd5 || rd_valid !== 1'b1 || ram_do !== m_rd) begin
        bad++;
        $display("FAIL simul_mid_%0d count=%0d rdv=%b do=%h want 5/1/%h", i, count, rd_valid, ram_do, m_rd);
      end
    end
    while (m_q.size() > 0) drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
    drive(1'b1, 1'b1, 1'b0, 8'h3C);
    total++; if (count !== 6'd1 || rd_valid !== 1'b0) begin bad++; $display("FAIL simul_empty count=%0d rdv=%b want 1/0", count, rd_valid); end
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (rd_valid !== 1'b1 || ram_do !== 8'h3C) begin bad++; $display("FAIL simul_empty_data rdv=%b do=%h want 1/3c", rd_valid, ram_do); end
    for (int i = 0; i < DEPTH; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h80 + i));
    push = 1'b1; pop = 1'b1;
    #1;
    total++; if (ram_we !== 1'b0 || ram_rce !== 1'b1) begin bad++; $display("FAIL simul_full_en we=%b rce=%b want 0/1", ram_we, ram_rce); end
    drive(1'b1, 1'b1, 1'b0, 8'h77);
    total++;
    if (count !== 6'd31 || rd_valid !== 1'b1 || ram_do !== 8'h80 || ^ram_do === 1'bx) begin
      bad++;
      $display("FAIL simul_full count=%0d rdv=%b do=%h want 31/1/80", count, rd_valid, ram_do);
    end
    while (m_q.size() > 0) begin
      drive(1'b0, 1'b1, 1'b0, 8'h00);
      total++; if (ram_do !== m_rd) begin bad++; $display("FAIL simul_full_drain do=%h want %h", ram_do, m_rd); end
    end
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_wrap();
    logic p, q;
    m_pushes = 0;
    for (int cyc = 0; cyc < 400; cyc++) begin
      if (((cyc / 25) % 2) == 0) begin
        p = ($urandom_range(0, 9) < 8);
        q = ($urandom_range(0, 9) < 3);
      end else begin
        p = ($urandom_range(0, 9) < 3);
        q = ($urandom_range(0, 9) < 8);
      end
      drive(p, q, 1'b0, 8'($urandom));
      total++;
      if (count !== 6'(m_q.size()) || full !== (m_q.size() == DEPTH) || empty !== (m_q.size() == 0) ||
          rd_valid !== m_rdv || (m_rdv && ram_do !== m_rd)) begin
        bad++;
        $display("FAIL wrap_%0d count=%0d full=%b empty=%b rdv=%b do=%h want %0d/%b/%h",
                 cyc, count, full, empty, rd_valid, ram_do, m_q.size(), m_rdv, m_rd);
      end
    end
    while (m_q.size() > 0) drive(1'b0, 1'b1, 1'b0, 8'h00);
    drive(1'b0, 1'b0, 1'b0, 8'h00);
  endtask

  task automatic test_flush();
    for (int i = 0; i < 12; i++) drive(1'b1, 1'b0, 1'b0, 8'(8'h20 + i));
    push = 1'b1; pop = 1'b1; clr = 1'b1;
    #1;
    total++; if (ram_we !== 1'b0 || ram_wce !== 1'b0 || ram_rce !== 1'b0) begin bad++; $display("FAIL flush_en we=%b wce=%b rce=%b want 0", ram_we, ram_wce, ram_rce); end
    drive(1'b1, 1'b1, 1'b1, 8'h99);
    total++; if (count !== 6'd0 || empty !== 1'b1 || rd_valid !== 1'b0) begin bad++; $display("FAIL flush_state count=%0d empty=%b rdv=%b want 0/1/0", count, empty, rd_valid); end
`ifdef FIFO_SC_ERR_EN
    total++; if (overflow !== m_ovf || underflow !== m_udf) begin bad++; $display("FAIL flush_err ovf=%b udf=%b want %b/%b", overflow, underflow, m_ovf, m_udf); end
`endif
    drive(1'b1, 1'b0, 1'b0, 8'h5A);
    drive(1'b0, 1'b1, 1'b0, 8'h00);
    total++; if (rd_valid !== 1'b1 || ram_do !== 8'h5A || ram_raddr !== 5'd1) begin bad++; $display("FAIL flush_after do=%h rdv=%b raddr=%0d want 5a/1/1", ram_do, rd_valid, ram_raddr); end
  endtask

  initial begin
    test_reset();
    test_reset_mid_burst();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
